// File: rtl/temp_hum_rx.sv
// ============================================================================
// temp_hum_rx : single-wire temperature/humidity sensor receiver.
//   Issues a start request, decodes the 40-bit pulse-width frame and checks it.
// Revision 1.0
// ============================================================================
`default_nettype none

module temp_hum_rx #(
  parameter int START_LOW_CYC  = 20,
  parameter int BIT_THRESH_CYC = 8,
  parameter int TIMEOUT_CYC    = 50,
  parameter int CNT_W          = 16
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       start,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_REL    = 3'd2;
  localparam logic [2:0] c_RESP_L = 3'd3;
  localparam logic [2:0] c_RESP_H = 3'd4;
  localparam logic [2:0] c_BIT_L  = 3'd5;
  localparam logic [2:0] c_BIT_H  = 3'd6;
  localparam logic [2:0] c_CHECK  = 3'd7;

  localparam logic [CNT_W-1:0] c_START_LAST = CNT_W'(START_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] c_TMO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] c_THRESH     = CNT_W'(BIT_THRESH_CYC);
  localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             sda_s1_q, sda_s2_q, sda_s3_q;
  logic             rise_q, fall_q;
  logic [5:0]       idx_q;
  logic [39:0]      shift_q;
  logic             done_q, err_q;
  logic [1:0]       err_code_q;
  logic [31:0]      bytes_q;
  logic             w_tmo;
  logic             w_limit;
  logic             w_bit;
  logic [7:0]       w_sum;

  always_ff @(posedge pclk) begin
    if (preset) state_q <= c_IDLE;
    else        state_q <= state_d;
  end

  // An expected edge always takes priority over the timeout compare.
  always_comb begin
    state_d = state_q;
    w_tmo   = 1'b0;
    w_limit = (cnt_q >= c_TMO_LAST);
    case (state_q)
      c_IDLE:   if (start) state_d = c_START;
      c_START:  if (cnt_q >= c_START_LAST) state_d = c_REL;
      c_REL: begin
        if (fall_q)       state_d = c_RESP_L;
        else if (w_limit) begin state_d = c_IDLE; w_tmo = 1'b1; end
      end
      c_RESP_L: begin
        if (rise_q)       state_d = c_RESP_H;
        else if (w_limit) begin state_d = c_IDLE; w_tmo = 1'b1; end
      end
      c_RESP_H: begin
        if (fall_q)       state_d = c_BIT_L;
        else if (w_limit) begin state_d = c_IDLE; w_tmo = 1'b1; end
      end
      c_BIT_L: begin
        if (rise_q)       state_d = c_BIT_H;
        else if (w_limit) begin state_d = c_IDLE; w_tmo = 1'b1; end
      end
      c_BIT_H: begin
        if (fall_q)       state_d = (idx_q == 6'd39) ? c_CHECK : c_BIT_L;
        else if (w_limit) begin state_d = c_IDLE; w_tmo = 1'b1; end
      end
      c_CHECK:  state_d = c_IDLE;
      default:  state_d = c_IDLE;
    endcase
  end

  always_comb begin
    sda_oe = (state_q == c_START);
    busy   = (state_q != c_IDLE);
  end

  // cnt_q holds (high cycles - 1) when the closing falling edge is consumed.
  assign w_bit = (cnt_q >= c_THRESH);
  assign w_sum = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  always_ff @(posedge pclk) begin
    if (preset) begin
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_s3_q   <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      bytes_q    <= '0;
    end else begin
      sda_s1_q <= sda_in;
      sda_s2_q <= sda_s1_q;
      sda_s3_q <= sda_s2_q;
      rise_q   <= sda_s2_q & ~sda_s3_q;
      fall_q   <= ~sda_s2_q & sda_s3_q;
      if (state_d != state_q)  cnt_q <= '0;
      else if (cnt_q != '1)    cnt_q <= cnt_q + c_ONE;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == c_RESP_H && fall_q) idx_q <= '0;
      if (state_q == c_BIT_H && fall_q) begin
        shift_q <= {shift_q[38:0], w_bit};
        idx_q   <= idx_q + 6'd1;
      end
      if (state_q == c_CHECK) begin
        if (w_sum == shift_q[7:0]) begin
          done_q     <= 1'b1;
          err_code_q <= 2'b00;
          bytes_q    <= shift_q[39:8];
        end else begin
          err_q      <= 1'b1;
          err_code_q <= 2'b10;
        end
      end
      if (w_tmo) begin
        err_q      <= 1'b1;
        err_code_q <= 2'b01;
      end
    end
  end

  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign hum_int  = bytes_q[31:24];
  assign hum_dec  = bytes_q[23:16];
  assign temp_int = bytes_q[15:8];
  assign temp_dec = bytes_q[7:0];

endmodule

`default_nettype wire

// File: tb/tb_temp_hum_rx.sv
// ============================================================================
// tb_temp_hum_rx : bench for temp_hum_rx with a behavioural sensor model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_temp_hum_rx;

  logic       pclk = 1'b0;
  logic       preset, start, sda_in, sda_oe, busy, done, err;
  logic [1:0] err_code;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
  logic       sda_lvl;

  int cmp_n  = 0;
  int fail_n = 0;
  int hi_len [40];
  int lo_len [40];
  int stall_at;
  logic [31:0] model_bytes;

  typedef struct {
    logic [39:0] bits;
    int          hi0;
    int          hi1;
    logic        exp_done;
    logic [1:0]  exp_code;
    logic [31:0] exp_bytes;
  } vec_t;
  vec_t tbl [5];

  always #5 pclk = ~pclk;

  // Open-drain line: host pull-down wins over the sensor's level.
  assign sda_in = sda_lvl & ~sda_oe;

  temp_hum_rx dut (
    .pclk(pclk), .preset(preset), .start(start), .sda_in(sda_in),
    .sda_oe(sda_oe), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    cmp_n++;
    fail_n++;
    $display("FAIL %s: wait bound expired (got no event, expected one)", nm);
  endtask

  function automatic logic [31:0] out_bytes();
    return {hum_int, hum_dec, temp_int, temp_dec};
  endfunction

  task automatic drive(input logic v, input int n);
    sda_lvl = v;
    repeat (n) tick();
  endtask

  task automatic fill_fixed(input logic [39:0] bits, input int hi0, input int hi1, input int lo);
    for (int i = 0; i < 40; i++) begin
      hi_len[i] = bits[39-i] ? hi1 : hi0;
      lo_len[i] = lo;
    end
    stall_at = -1;
  endtask

  // Sensor: waits for the host start window, answers, then sends 40 bits.
  task automatic sensor_run();
    int n;
    n = 0;
    while (!sda_oe && n < 200) begin tick(); n++; end
    if (n >= 200) bound_fail("sensor start seen");
    n = 0;
    while (sda_oe && n < 200) begin tick(); n++; end
    if (n >= 200) bound_fail("sensor release seen");
    drive(1'b1, 2);
    drive(1'b0, 10);
    drive(1'b1, 10);
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, lo_len[i]);
      if (stall_at == i) return;
      drive(1'b1, hi_len[i]);
    end
    drive(1'b0, 5);
    sda_lvl = 1'b1;
  endtask

  task automatic run_txn(input string nm, input logic exp_done, input logic [1:0] exp_code,
                         input logic [31:0] exp_bytes);
    logic [1:0]  pulse;
    logic [1:0]  code;
    logic [31:0] by;
    logic        bsy;
    int          n;
    sda_lvl = 1'b1;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    fork
      sensor_run();
      begin
        n = 0;
        while (!(done || err) && n < 4000) begin tick(); n++; end
        pulse = {done, err};
        code  = err_code;
        by    = out_bytes();
        bsy   = busy;
        tick();
        check({nm, " pulse width"}, 40'({done, err}), 40'(2'b00));
      end
    join
    check({nm, " pulse"}, 40'(pulse), 40'({exp_done, ~exp_done}));
    check({nm, " err_code"}, 40'(code), 40'(exp_code));
    check({nm, " bytes"}, 40'(by), 40'(exp_bytes));
    check({nm, " busy at pulse"}, 40'(bsy), 40'(1'b0));
  endtask

  initial begin
    int n, oe_n, d_n, e_n;
    logic early;
    logic [31:0] b;
    logic [7:0]  chk, dsum;
    logic [39:0] dec;
    logic        exp_d;
    logic [1:0]  exp_c;

    tbl[0] = '{40'h37_00_19_00_50, 5, 12, 1'b1, 2'b00, 32'h3700_1900};
    tbl[1] = '{40'h37_00_19_00_51, 5, 12, 1'b0, 2'b10, 32'h3700_1900};
    tbl[2] = '{40'hFF_FF_FF_FF_00, 3,  8, 1'b1, 2'b00, 32'h0000_0000};
    tbl[3] = '{40'hFF_FF_FF_FF_FC, 5,  9, 1'b1, 2'b00, 32'hFFFF_FFFF};
    tbl[4] = '{40'h12_34_56_78_14, 2, 20, 1'b1, 2'b00, 32'h1234_5678};

    preset = 1'b1; start = 1'b0; sda_lvl = 1'b1; model_bytes = '0;
    repeat (3) tick();
    check("reset sda_oe", 40'(sda_oe), 40'(1'b0));
    check("reset busy", 40'(busy), 40'(1'b0));
    check("reset pulses", 40'({done, err}), 40'(2'b00));
    check("reset err_code", 40'(err_code), 40'(2'b00));
    check("reset bytes", 40'(out_bytes()), 40'(32'h0));
    preset = 1'b0;
    repeat (2) tick();

    // Reset in the 10th cycle of the start window.
    start = 1'b1; tick(); start = 1'b0;
    repeat (9) tick();
    check("midstart sda_oe before", 40'(sda_oe), 40'(1'b1));
    preset = 1'b1; tick(); preset = 1'b0;
    check("midstart sda_oe", 40'(sda_oe), 40'(1'b0));
    check("midstart busy", 40'(busy), 40'(1'b0));
    early = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (done || err || sda_oe || busy) early = 1'b1;
      tick();
    end
    check("midstart quiet after", 40'(early), 40'(1'b0));

    for (int i = 0; i < 5; i++) begin
      fill_fixed(tbl[i].bits, tbl[i].hi0, tbl[i].hi1, 6);
      run_txn($sformatf("vec%0d", i), tbl[i].exp_done, tbl[i].exp_code, tbl[i].exp_bytes);
      model_bytes = tbl[i].exp_bytes;
    end

    // Sensor never answers: timeout exactly TIMEOUT_CYC after release.
    sda_lvl = 1'b1;
    repeat (5) tick();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (sda_oe && n < 100) begin tick(); n++; end
    check("start window length", 40'(n), 40'(20));
    check("busy in REL", 40'(busy), 40'(1'b1));
    early = 1'b0;
    for (int j = 1; j < 50; j++) begin
      tick();
      if (done || err) early = 1'b1;
    end
    tick();
    check("timeout early pulse", 40'(early), 40'(1'b0));
    check("timeout pulse", 40'({done, err}), 40'(2'b01));
    check("timeout err_code", 40'(err_code), 40'(2'b01));
    check("timeout bytes", 40'(out_bytes()), 40'(model_bytes));
    fill_fixed(40'h37_00_19_00_50, 5, 12, 6);
    run_txn("after timeout", 1'b1, 2'b00, 32'h3700_1900);
    model_bytes = 32'h3700_1900;

    // Repeated start while busy: one window, one done.
    fill_fixed(40'hA5_5A_0F_F0_FE, 4, 11, 5);
    sda_lvl = 1'b1;
    repeat (5) tick();
    oe_n = 0; d_n = 0; e_n = 0;
    fork
      sensor_run();
      for (int i = 0; i < 1500; i++) begin
        start = (i < 100) && (i % 2 == 0);
        tick();
        if (sda_oe) oe_n++;
        if (done)   d_n++;
        if (err)    e_n++;
      end
    join
    start = 1'b0;
    check("restart oe cycles", 40'(oe_n), 40'(20));
    check("restart done count", 40'(d_n), 40'(1));
    check("restart err count", 40'(e_n), 40'(0));
    check("restart bytes", 40'(out_bytes()), 40'(32'hA55A_0FF0));
    model_bytes = 32'hA55A_0FF0;

    // Randomised frames against the frame-level model.
    for (int t = 0; t < 20; t++) begin
      b   = $urandom;
      chk = 8'((int'(b[31:24]) + int'(b[23:16]) + int'(b[15:8]) + int'(b[7:0])) % 256);
      if ($urandom_range(0, 2) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      for (int i = 0; i < 40; i++) begin
        lo_len[i] = $urandom_range(1, 20);
        hi_len[i] = ({b, chk}[39-i]) ? $urandom_range(9, 30) : $urandom_range(1, 8);
      end
      stall_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 39) : -1;
      for (int i = 0; i < 40; i++) dec[39-i] = (hi_len[i] > 8);
      dsum = 8'((int'(dec[39:32]) + int'(dec[31:24]) + int'(dec[23:16]) + int'(dec[15:8])) % 256);
      if (stall_at >= 0) begin
        exp_d = 1'b0; exp_c = 2'b01;
      end else if (dsum == dec[7:0]) begin
        exp_d = 1'b1; exp_c = 2'b00; model_bytes = dec[39:8];
      end else begin
        exp_d = 1'b0; exp_c = 2'b10;
      end
      run_txn($sformatf("rnd%0d", t), exp_d, exp_c, model_bytes);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule

`default_nettype wire
